uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver. It adds:
- configurable data width, oversampling ratio, parity mode and stop-bit count;
- an input synchroniser;
- a valid/ready output holding register;
- per-frame parity and framing error flags, plus a sticky overrun flag.

It sits between the serial pin and the controller's receive data path. rx_clk is the oversampling clock: OVERSAMPLE cycles per bit period.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, rx_clk cycles per bit, even, legal 8..32
PARITY_EN, 1, 1 = parity bit present after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits checked, legal 1 or 2

Ports:
rx_clk  input  1  receiver clock (oversampling clock)
rx_rst_n  input  1  asynchronous active-low reset
rx_en  input  1  receiver enable; low = synchronous abort to IDLE
i_rx  input  1  serial data in, asynchronous to rx_clk, idle high
rx_o_ready  input  1  downstream accepts held frame
rx_o_data  output  DATA_BITS  received data word
rx_o_data_valid  output  1  holding register full
rx_o_parity_err  output  1  parity mismatch for held frame
rx_o_frame_err  output  1  a stop bit sampled low for held frame
rx_o_overrun  output  1  sticky: a frame completed while holding register was full
rx_o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rx_rst_n low, asynchronous):
  - all outputs 0, state IDLE, counters 0;
  - both synchroniser flops set to 1 (line idle).
- Synchroniser: i_rx passes through 2 flops; the FSM uses only the synchronised sample s_rx.
- The falling-edge detector uses the previous s_rx, which must be 1. A line held low never restarts a frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on s_rx falling edge -> START, cycle counter cnt = 0.
  - START: at cnt == OVERSAMPLE/2-1 (mid start bit):
    - s_rx low -> DATA, cnt = 0, bit index = 0;
    - s_rx high -> IDLE (glitch rejected, no output).
  - DATA: sample s_rx at cnt == OVERSAMPLE-1 into bit[index], LSB first, then cnt = 0.
    - After the DATA_BITS-th sample -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample at cnt == OVERSAMPLE-1.
    - Parity error = (XOR of data bits XOR sampled bit) != PARITY_ODD.
    - Then -> STOP.
  - STOP: sample at cnt == OVERSAMPLE-1 for each of STOP_BITS stop bits.
    - Any low sample sets frame error.
    - After the last stop sample the frame is complete -> IDLE.
- Delivery: on the cycle after frame completion:
  - If the holding register is empty or being accepted that cycle: load rx_o_data with the error flags and set rx_o_data_valid.
  - Otherwise: the held frame is retained, the new frame is dropped, and rx_o_overrun is set.
- Handshake:
  - Transfer occurs when rx_o_data_valid && rx_o_ready on a rising rx_clk edge. Valid clears on that edge unless a new frame loads the same edge.
  - Data and error flags are stable while valid is high.
  - rx_o_overrun clears on the next transfer edge.
- Latency: the first rx_clk edge sampling i_rx low is edge 0. Valid rises at edge 2 + OVERSAMPLE/2 + (DATA_BITS + PARITY_EN + STOP_BITS)*OVERSAMPLE + 1. For the 8E1 default at OVERSAMPLE=16 this is edge 171; for 8N1 it is edge 155.
- Back-to-back frames: from IDLE, a new start edge is accepted on the cycle after STOP exits. There is no idle gap requirement beyond a high stop bit.
- Framing error:
  - The frame is still delivered with rx_o_frame_err = 1.
  - The FSM returns to IDLE, and a held-low line (break) is ignored until s_rx returns high.
- rx_en low:
  - next edge: state IDLE, counters 0, rx_o_busy 0;
  - the holding register, valid and overrun are retained;
  - a partial frame is discarded.
- Reset mid-frame: immediate return to reset values, no partial output.
- Counter width: ceil(log2(OVERSAMPLE)) bits. Bit index: ceil(log2(DATA_BITS + 1)) bits.

Test Plan:
1. Defaults (8E1, OS=16), rx_o_ready=1, send 0xA5 with even parity bit 0 -> at edge 171: rx_o_data=0xA5, valid for 1 cycle, parity_err=0, frame_err=0.
2. DATA_BITS=8, PARITY_EN=0: send 0x3C with stop bit forced low -> rx_o_data=0x3C, frame_err=1; a line held low for 40 bit-times produces no further frames; after line high, 0x81 is received cleanly.
3. Defaults: send 0x01 with parity bit 0 (wrong for even) -> rx_o_data=0x01, parity_err=1. Repeat with PARITY_ODD=1 and parity bit 0 -> parity_err=0.
4. rx_o_ready=0, send 0x11 then 0x22 -> rx_o_data stays 0x11, overrun=1. Raise ready for 1 cycle -> valid=0, overrun=0. Next frame 0x33 is delivered.
5. Start-bit glitch: i_rx low for 4 cycles then high -> rx_o_busy pulses, returns to IDLE at mid-start, no valid. Drop rx_en mid-DATA -> busy=0 next edge, no output.
6. DATA_BITS=5, STOP_BITS=2, OS=8: send 0x1F; low second stop bit on a second frame -> first frame frame_err=0, second frame_err=1. Assert rx_rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with configurable frame format and a valid/ready holding register.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst_n,
  input  logic                 rx_en,
  input  logic                 i_rx,
  input  logic                 rx_o_ready,
  output logic [DATA_BITS-1:0] rx_o_data,
  output logic                 rx_o_data_valid,
  output logic                 rx_o_parity_err,
  output logic                 rx_o_frame_err,
  output logic                 rx_o_overrun,
  output logic                 rx_o_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] I_STOP = IW'(STOP_BITS - 1);
  localparam logic P_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]           r_sync;
  logic                 r_prev;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_done;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_pe;
  logic                 r_fe;
  logic                 r_ovr;
  logic                 w_s_rx;
  logic                 w_tick;
  logic                 w_xfer;

  assign w_s_rx = r_sync[1];
  assign w_tick = (r_cnt == C_FULL);
  assign w_xfer = r_valid && rx_o_ready;

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_prev <= r_sync[1];
    end
  end

  // r_prev must be high for a start, so a held-low break never re-triggers a frame
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else if (!rx_en) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_prev && !w_s_rx) r_state <= S_START;
        end
        S_START: if (r_cnt == C_HALF) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_perr  <= 1'b0;
          r_ferr  <= 1'b0;
          r_state <= w_s_rx ? S_IDLE : S_DATA;
        end
        S_DATA: if (w_tick) begin
          r_cnt   <= '0;
          r_shift <= {w_s_rx, r_shift[DATA_BITS-1:1]};
          r_idx   <= r_idx + 1'b1;
          if (r_idx == I_LAST) begin
            r_idx   <= '0;
            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: if (w_tick) begin
          r_cnt   <= '0;
          r_perr  <= ^r_shift ^ w_s_rx ^ P_ODD;
          r_state <= S_STOP;
        end
        S_STOP: if (w_tick) begin
          r_cnt  <= '0;
          r_ferr <= r_ferr | ~w_s_rx;
          r_idx  <= r_idx + 1'b1;
          if (r_idx == I_STOP) begin
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_done && (!r_valid || rx_o_ready)) begin
        r_data  <= r_shift;
        r_pe    <= r_perr;
        r_fe    <= r_ferr;
        r_valid <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) r_ovr <= 1'b0;
      else if (r_done && r_valid) r_ovr <= 1'b1;
    end
  end

  assign rx_o_data       = r_data;
  assign rx_o_data_valid = r_valid;
  assign rx_o_parity_err = r_pe;
  assign rx_o_frame_err  = r_fe;
  assign rx_o_overrun    = r_ovr;
  assign rx_o_busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into four differently configured receivers with hand-computed results.
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic rdy = 1'b1;
  logic [3:0] rx = 4'hF;
  logic [7:0] dat [4];
  logic [4:0] d3;
  logic [3:0] v, pe, fe, ov, bz;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int nf [4];
  int lc [4];
  int t0 [4];
  logic [7:0] ld [4];
  logic [3:0] lpe, lfe;
  logic [3:0] pv = 4'h0;
  int base;
  int lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // u0: 8E1 OS16, u1: 8N1, u2: 8O1, u3: 5E2 OS8
  uart_rx_cfg u0 (.rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en), .i_rx(rx[0]), .rx_o_ready(rdy),
    .rx_o_data(dat[0]), .rx_o_data_valid(v[0]), .rx_o_parity_err(pe[0]), .rx_o_frame_err(fe[0]),
    .rx_o_overrun(ov[0]), .rx_o_busy(bz[0]));
  uart_rx_cfg #(.PARITY_EN(0)) u1 (.rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en), .i_rx(rx[1]), .rx_o_ready(rdy),
    .rx_o_data(dat[1]), .rx_o_data_valid(v[1]), .rx_o_parity_err(pe[1]), .rx_o_frame_err(fe[1]),
    .rx_o_overrun(ov[1]), .rx_o_busy(bz[1]));
  uart_rx_cfg #(.PARITY_ODD(1)) u2 (.rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en), .i_rx(rx[2]), .rx_o_ready(rdy),
    .rx_o_data(dat[2]), .rx_o_data_valid(v[2]), .rx_o_parity_err(pe[2]), .rx_o_frame_err(fe[2]),
    .rx_o_overrun(ov[2]), .rx_o_busy(bz[2]));
  uart_rx_cfg #(.DATA_BITS(5), .OVERSAMPLE(8), .STOP_BITS(2)) u3 (.rx_clk(clk), .rx_rst_n(rst_n), .rx_en(en),
    .i_rx(rx[3]), .rx_o_ready(rdy), .rx_o_data(d3), .rx_o_data_valid(v[3]), .rx_o_parity_err(pe[3]),
    .rx_o_frame_err(fe[3]), .rx_o_overrun(ov[3]), .rx_o_busy(bz[3]));
  assign dat[3] = {3'b000, d3};

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (v[d] && !pv[d]) begin
        nf[d]++;
        ld[d] = dat[d];
        lpe[d] = pe[d];
        lfe[d] = fe[d];
        lc[d] = cyc;
      end
      pv[d] = v[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // frame bit 0 is the start bit; each level is held os cycles
  task automatic send(input int d, input logic [15:0] f, input int n, input int os);
    t0[d] = cyc + 1;
    for (int i = 0; i < n; i++) begin
      rx[d] = f[i];
      step(os);
    end
  endtask

  initial begin
    step(3);
    check("rst_valid", 32'(v), 32'h0);
    check("rst_busy", 32'(bz), 32'h0);
    check("rst_data", 32'(dat[0]), 32'h0);
    rst_n = 1'b1;
    step(5);

    base = nf[0];
    send(0, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16);
    step(4);
    lat = lc[0] - t0[0];
    check("a5_frames", 32'(nf[0] - base), 32'd1);
    check("a5_data", 32'(ld[0]), 32'hA5);
    check("a5_perr", 32'(lpe[0]), 32'h0);
    check("a5_ferr", 32'(lfe[0]), 32'h0);
    check("a5_latency", 32'(lat), 32'd171);
    check("a5_valid_1cyc", 32'(v[0]), 32'h0);

    base = nf[1];
    send(1, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, 16);
    step(640);
    lat = lc[1] - t0[1];
    check("3c_latency", 32'(lat), 32'd155);
    check("3c_frames", 32'(nf[1] - base), 32'd1);
    check("3c_data", 32'(ld[1]), 32'h3C);
    check("3c_ferr", 32'(lfe[1]), 32'h1);
    check("break_busy", 32'(bz[1]), 32'h0);
    rx[1] = 1'b1;
    step(16);
    send(1, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 16);
    step(4);
    check("81_frames", 32'(nf[1] - base), 32'd2);
    check("81_data", 32'(ld[1]), 32'h81);
    check("81_ferr", 32'(lfe[1]), 32'h0);

    send(0, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 16);
    step(4);
    check("01e_data", 32'(ld[0]), 32'h01);
    check("01e_perr", 32'(lpe[0]), 32'h1);
    send(2, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, 16);
    step(4);
    check("01o_data", 32'(ld[2]), 32'h01);
    check("01o_perr", 32'(lpe[2]), 32'h0);

    rdy = 1'b0;
    base = nf[0];
    send(0, {5'b0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, 16);
    send(0, {5'b0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, 16);
    step(4);
    check("ovr_frames", 32'(nf[0] - base), 32'd1);
    check("ovr_data", 32'(dat[0]), 32'h11);
    check("ovr_valid", 32'(v[0]), 32'h1);
    check("ovr_flag", 32'(ov[0]), 32'h1);
    rdy = 1'b1;
    step(1);
    rdy = 1'b0;
    check("xfer_valid", 32'(v[0]), 32'h0);
    check("xfer_ovr", 32'(ov[0]), 32'h0);
    rdy = 1'b1;
    send(0, {5'b0, 1'b1, 1'b0, 8'h33, 1'b0}, 11, 16);
    step(4);
    check("33_data", 32'(ld[0]), 32'h33);
    check("33_frames", 32'(nf[0] - base), 32'd2);

    base = nf[0];
    rx[0] = 1'b0;
    step(4);
    rx[0] = 1'b1;
    check("glitch_busy", 32'(bz[0]), 32'h1);
    step(20);
    check("glitch_idle", 32'(bz[0]), 32'h0);
    check("glitch_noframe", 32'(nf[0] - base), 32'd0);

    rx[0] = 1'b0;
    step(48);
    check("data_busy", 32'(bz[0]), 32'h1);
    en = 1'b0;
    step(1);
    check("en_abort_busy", 32'(bz[0]), 32'h0);
    rx[0] = 1'b1;
    step(20);
    en = 1'b1;
    step(200);
    check("en_noframe", 32'(nf[0] - base), 32'd0);
    check("en_keep_data", 32'(dat[0]), 32'h33);

    base = nf[3];
    send(3, {7'b0, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b0}, 9, 8);
    step(4);
    lat = lc[3] - t0[3];
    check("1f_latency", 32'(lat), 32'd71);
    check("1f_data", 32'(ld[3]), 32'h1F);
    check("1f_perr", 32'(lpe[3]), 32'h0);
    check("1f_ferr", 32'(lfe[3]), 32'h0);
    send(3, {7'b0, 1'b0, 1'b1, 1'b1, 5'h1F, 1'b0}, 9, 8);
    rx[3] = 1'b1;
    step(10);
    check("1f2_frames", 32'(nf[3] - base), 32'd2);
    check("1f2_ferr", 32'(lfe[3]), 32'h1);

    rx[0] = 1'b0;
    step(50);
    check("pre_rst_busy", 32'(bz[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bz[0]), 32'h0);
    check("mid_rst_data", 32'(dat[0]), 32'h0);
    check("mid_rst_valid", 32'(v[0]), 32'h0);
    check("mid_rst_ferr", 32'(fe[3]), 32'h0);
    rx[0] = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
